// File: rtl/affine_seq_if.sv
// Pin and ALU/register-file signals shared between the affine sequencer and its datapath.
// master = sequencer side, slave = ALU / register file / board side.
interface affine_seq_if;
    logic       Btn;
    logic [7:0] ACC;
    logic [7:0] Imm;
    logic [2:0] Func;
    logic       WE;
    logic       SelSW;
    logic       SelImm;
    logic       UseMul;
    logic       UseACC;
    logic [2:0] RegAddr;
    logic       RegWE;
    logic [7:0] Led;
    logic       Busy;
    logic       Done;

    modport master (
        input  Btn, ACC,
        output Imm, Func, WE, SelSW, SelImm, UseMul, UseACC, RegAddr, RegWE, Led, Busy, Done
    );

    modport slave (
        output Btn, ACC,
        input  Imm, Func, WE, SelSW, SelImm, UseMul, UseACC, RegAddr, RegWE, Led, Busy, Done
    );
endinterface

// File: rtl/affine_seq.sv
// Microsequencer: captures x1/y1 via button presses, then drives the ALU through a fixed
// 16-step program computing a 2-D affine transform, and shows x2 then y2 on Led.
module affine_seq #(
    parameter logic signed [7:0] A11 = 8'sd6,
    parameter logic signed [7:0] A12 = 8'sd4,
    parameter logic signed [7:0] B1  = 8'sd20,
    parameter logic signed [7:0] A21 = -8'sd4,
    parameter logic signed [7:0] A22 = 8'sd6,
    parameter logic signed [7:0] B2  = -8'sd20
) (
    input  logic          Clock,
    input  logic          nReset,
    affine_seq_if.master  bus
);
    localparam logic [2:0] RegX1 = 3'd0;
    localparam logic [2:0] RegY1 = 3'd1;
    localparam logic [2:0] RegT  = 3'd2;
    localparam logic [2:0] RegX2 = 3'd3;
    localparam logic [2:0] RegY2 = 3'd4;

    typedef enum logic [3:0] {
        StWaitPx, StLoadX, StStoreX, StWaitRx, StWaitPy, StLoadY, StStoreY, StWaitRy,
        StCalc, StShowX, StWaitR2, StShowY
    } state_e;

    state_e     state_q, state_d;
    logic [3:0] step_q, step_d;
    logic [7:0] led_q, led_d;
    logic [7:0] y2h_q, y2h_d;
    logic       btn_meta_q, bs_q, bs_prev_q;
    logic       press, release_seen;

    // Edge history runs in every state, so an edge that lands during CALC is consumed there.
    assign press        = bs_q & ~bs_prev_q;
    assign release_seen = ~bs_q;

    always_ff @(posedge Clock or negedge nReset) begin
        if (!nReset) begin
            state_q    <= StWaitPx;
            step_q     <= 4'd0;
            led_q      <= 8'd0;
            y2h_q      <= 8'd0;
            btn_meta_q <= 1'b0;
            bs_q       <= 1'b0;
            bs_prev_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            step_q     <= step_d;
            led_q      <= led_d;
            y2h_q      <= y2h_d;
            btn_meta_q <= bus.Btn;
            bs_q       <= btn_meta_q;
            bs_prev_q  <= bs_q;
        end
    end

    always_comb begin
        state_d = state_q;
        step_d  = step_q;
        led_d   = led_q;
        y2h_d   = y2h_q;
        case (state_q)
            StWaitPx, StShowY: if (press) state_d = StLoadX;
            StLoadX:           state_d = StStoreX;
            StStoreX:          state_d = StWaitRx;
            StWaitRx:          if (release_seen) state_d = StWaitPy;
            StWaitPy:          if (press) state_d = StLoadY;
            StLoadY:           state_d = StStoreY;
            StStoreY:          state_d = StWaitRy;
            StWaitRy: begin
                if (release_seen) begin
                    state_d = StCalc;
                    step_d  = 4'd0;
                end
            end
            StCalc: begin
                step_d = step_q + 4'd1;
                if (step_q == 4'd7) led_d = bus.ACC;
                if (step_q == 4'd15) begin
                    y2h_d   = bus.ACC;
                    state_d = StShowX;
                end
            end
            StShowX:           if (press) state_d = StWaitR2;
            StWaitR2: begin
                if (release_seen) begin
                    state_d = StShowY;
                    led_d   = y2h_q;
                end
            end
            default:           state_d = StWaitPx;
        endcase
    end

    logic [7:0] imm;
    logic       we, sel_sw, sel_imm, use_mul, use_acc, reg_we, busy, done;
    logic [2:0] reg_addr;
    logic       second;

    // step[3] selects the y2 half of the program; both halves share the same op sequence.
    assign second = step_q[3];

    always_comb begin
        imm      = 8'd0;
        we       = 1'b0;
        sel_sw   = 1'b0;
        sel_imm  = 1'b0;
        use_mul  = 1'b0;
        use_acc  = 1'b0;
        reg_we   = 1'b0;
        reg_addr = 3'd0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state_q)
            StLoadX, StLoadY: begin
                sel_sw = 1'b1;
                we     = 1'b1;
            end
            StStoreX: begin
                reg_we   = 1'b1;
                reg_addr = RegX1;
            end
            StStoreY: begin
                reg_we   = 1'b1;
                reg_addr = RegY1;
            end
            StCalc: begin
                busy = 1'b1;
                case (step_q[2:0])
                    3'd0: begin we = 1'b1; reg_addr = RegX1; end
                    3'd1: begin
                        we = 1'b1; use_mul = 1'b1; use_acc = 1'b1;
                        imm = second ? A21 : A11;
                    end
                    3'd2: begin reg_we = 1'b1; reg_addr = RegT; end
                    3'd3: begin we = 1'b1; reg_addr = RegY1; end
                    3'd4: begin
                        we = 1'b1; use_mul = 1'b1; use_acc = 1'b1;
                        imm = second ? A22 : A12;
                    end
                    3'd5: begin we = 1'b1; use_acc = 1'b1; reg_addr = RegT; end
                    3'd6: begin
                        we = 1'b1; sel_imm = 1'b1; use_acc = 1'b1;
                        imm = second ? B2 : B1;
                    end
                    default: begin reg_we = 1'b1; reg_addr = second ? RegY2 : RegX2; end
                endcase
            end
            StShowX, StShowY: done = 1'b1;
            default: ;
        endcase
    end

    assign bus.Imm     = imm;
    assign bus.Func    = 3'b000;
    assign bus.WE      = we;
    assign bus.SelSW   = sel_sw;
    assign bus.SelImm  = sel_imm;
    assign bus.UseMul  = use_mul;
    assign bus.UseACC  = use_acc;
    assign bus.RegAddr = reg_addr;
    assign bus.RegWE   = reg_we;
    assign bus.Led     = led_q;
    assign bus.Busy    = busy;
    assign bus.Done    = done;
endmodule

// File: tb/tb_affine_seq.sv
// Directed bench for affine_seq with a behavioural ALU and register file around it.
module tb_affine_seq;
    logic       clk = 1'b0;
    logic       nreset = 1'b0;
    logic       btn = 1'b0;
    logic [7:0] sw = 8'd0;
    logic [7:0] acc_q;
    logic [7:0] rf [8];
    int         n_checks = 0;
    int         n_fail = 0;

    always #5 clk = ~clk;

    affine_seq_if sif();
    assign sif.Btn = btn;
    assign sif.ACC = acc_q;

    affine_seq dut (
        .Clock  (clk),
        .nReset (nreset),
        .bus    (sif)
    );

    // Behavioural ALU: add, or signed multiply by a Q3 immediate truncated to 8 bits.
    logic [7:0]         alu_data;
    logic signed [15:0] prod;
    always_comb begin
        alu_data = sif.SelSW ? sw : (sif.SelImm ? sif.Imm : rf[sif.RegAddr]);
        prod     = $signed(acc_q) * $signed(sif.Imm);
    end

    always @(posedge clk) begin
        if (sif.WE) begin
            if (sif.UseMul)      acc_q <= prod[10:3];
            else if (sif.UseACC) acc_q <= acc_q + alu_data;
            else                 acc_q <= alu_data;
        end
        if (sif.RegWE) rf[sif.RegAddr] <= acc_q;
    end

    logic [16:0] ctl_obs;
    assign ctl_obs = {sif.WE, sif.SelSW, sif.SelImm, sif.UseMul, sif.UseACC, sif.RegWE,
                      sif.RegAddr, sif.Imm};

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
        end
    endtask

    // {WE,SelSW,SelImm,UseMul,UseACC,RegWE}, RegAddr, Imm for each CALC step.
    function automatic logic [16:0] exp_ctl(input int s);
        case (s)
            0:       return {6'b100000, 3'd0, 8'h00};  // LDR X1
            1:       return {6'b100110, 3'd0, 8'h06};  // MULI A11
            2:       return {6'b000001, 3'd2, 8'h00};  // ST T
            3:       return {6'b100000, 3'd1, 8'h00};  // LDR Y1
            4:       return {6'b100110, 3'd0, 8'h04};  // MULI A12
            5:       return {6'b100010, 3'd2, 8'h00};  // ADDR T
            6:       return {6'b101010, 3'd0, 8'h14};  // ADDI B1
            7:       return {6'b000001, 3'd3, 8'h00};  // ST X2
            8:       return {6'b100000, 3'd0, 8'h00};
            9:       return {6'b100110, 3'd0, 8'hFC};  // MULI A21 = -4
            10:      return {6'b000001, 3'd2, 8'h00};
            11:      return {6'b100000, 3'd1, 8'h00};
            12:      return {6'b100110, 3'd0, 8'h06};
            13:      return {6'b100010, 3'd2, 8'h00};
            14:      return {6'b101010, 3'd0, 8'hEC};  // ADDI B2 = -20
            default: return {6'b000001, 3'd4, 8'h00};  // ST Y2
        endcase
    endfunction

    task automatic capture(input logic [7:0] v);
        @(negedge clk);
        sw  = v;
        btn = 1'b1;
        repeat (6) @(negedge clk);
        btn = 1'b0;
    endtask

    task automatic wait_busy();
        for (int k = 0; k < 20 && !sif.Busy; k++) @(negedge clk);
        check_eq("busy_start", {31'd0, sif.Busy}, 32'd1);
    endtask

    task automatic trace_calc(input logic [7:0] x2_exp);
        for (int i = 0; i < 16; i++) begin
            check_eq($sformatf("ctl_step%0d", i), {15'd0, ctl_obs}, {15'd0, exp_ctl(i)});
            check_eq($sformatf("busy_step%0d", i), {31'd0, sif.Busy}, 32'd1);
            check_eq("func_zero", {29'd0, sif.Func}, 32'd0);
            if (i == 8) check_eq("led_x2_after_step7", {24'd0, sif.Led}, {24'd0, x2_exp});
            @(negedge clk);
        end
        check_eq("busy_end", {31'd0, sif.Busy}, 32'd0);
        check_eq("done_showx", {31'd0, sif.Done}, 32'd1);
    endtask

    task automatic press_release();
        @(negedge clk);
        btn = 1'b1;
        repeat (5) @(negedge clk);
        check_eq("done_low_wait_r2", {31'd0, sif.Done}, 32'd0);
        btn = 1'b0;
        repeat (5) @(negedge clk);
    endtask

    task automatic full_run_16_8();
        capture(8'd16);
        repeat (5) @(negedge clk);
        capture(8'd8);
        wait_busy();
        trace_calc(8'h24);
        check_eq("led_x2_36", {24'd0, sif.Led}, 32'h24);
        press_release();
        check_eq("led_y2_m22", {24'd0, sif.Led}, 32'hEA);
        check_eq("done_showy", {31'd0, sif.Done}, 32'd1);
    endtask

    initial begin
        // Reset held with button activity
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            btn = ~btn;
        end
        btn = 1'b0;
        check_eq("rst_ctl", {15'd0, ctl_obs}, 32'd0);
        check_eq("rst_led", {24'd0, sif.Led}, 32'd0);
        check_eq("rst_busy_done", {30'd0, sif.Busy, sif.Done}, 32'd0);
        check_eq("rst_func", {29'd0, sif.Func}, 32'd0);
        repeat (3) @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        check_eq("idle_ctl", {15'd0, ctl_obs}, 32'd0);

        // Basic run: x1 = 16, y1 = 8 -> 36, -22
        full_run_16_8();

        // Wrap case: x1 = -128, y1 = 127
        // x2 = -96 + 63 + 20 = -13 (0xF3); y2 = 64 + 95 wraps to -97, -20 -> -117 (0x8B)
        capture(8'h80);
        repeat (5) @(negedge clk);
        capture(8'h7F);
        wait_busy();
        sw = 8'd99;
        for (int i = 0; i < 16; i++) begin
            if (i == 0 || i == 4 || i == 8) btn = 1'b1;
            if (i == 1 || i == 5) btn = 1'b0;
            @(negedge clk);
        end
        check_eq("wrap_done", {31'd0, sif.Done}, 32'd1);
        check_eq("wrap_led_x2", {24'd0, sif.Led}, 32'hF3);
        repeat (10) @(negedge clk);
        check_eq("held_btn_no_advance", {31'd0, sif.Done}, 32'd1);
        check_eq("held_btn_led", {24'd0, sif.Led}, 32'hF3);
        btn = 1'b0;
        repeat (4) @(negedge clk);
        press_release();
        check_eq("wrap_led_y2", {24'd0, sif.Led}, 32'h8B);

        // Reset at CALC step 5 aborts at once
        capture(8'd16);
        repeat (5) @(negedge clk);
        capture(8'd8);
        wait_busy();
        repeat (5) @(negedge clk);
        check_eq("pre_abort_step5", {15'd0, ctl_obs}, {15'd0, exp_ctl(5)});
        nreset = 1'b0;
        #1;
        check_eq("abort_ctl", {15'd0, ctl_obs}, 32'd0);
        check_eq("abort_busy", {31'd0, sif.Busy}, 32'd0);
        check_eq("abort_led", {24'd0, sif.Led}, 32'd0);
        @(negedge clk);
        nreset = 1'b1;
        repeat (3) @(negedge clk);
        full_run_16_8();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1);
    end
endmodule
